// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_LOAD = 1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arb_age_ctr.sv
// Saturating count of cycles port 1 has been denied; at_max hands it priority.
module mem_arb_age_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [CNT_W-1:0] cnt;

    assign at_max = (cnt == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: core (port 0) vs loader/DMA (port 1) with burst lock.
// Define MEM_ARB_AGE_EN to add the port 1 aging counter (bounded wait of MAX_WAIT).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    arb_state_t state, state_nxt;
    logic       age_win;
    logic       win_load;
    logic       rv0_q, rv1_q;

`ifdef MEM_ARB_AGE_EN
    logic at_max;

    mem_arb_age_ctr #(.MAX_WAIT(MAX_WAIT)) u_age_ctr (
        .clk    (clk),
        .reset  (reset),
        .inc    (req1 & ~gnt1),
        .clr    (gnt1 | ~req1),
        .at_max (at_max)
    );

    assign age_win = at_max;
`else
    logic unused_max_wait;

    assign unused_max_wait = ^MAX_WAIT;
    assign age_win         = 1'b0;
`endif

    // Grant selection and lock tracking; grants held low while in reset.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (reset) begin
            case (state)
                ST_ARB: begin
                    if (req1 && (!req0 || age_win)) begin
                        gnt1 = 1'b1;
                        if (lock1) begin
                            state_nxt = ST_LOCKED;
                        end
                    end else if (req0) begin
                        gnt0 = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    gnt1 = req1;
                    if (!lock1) begin
                        state_nxt = ST_ARB;
                    end
                end
                default: state_nxt = ST_ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_ARB;
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rv0_q <= gnt0 & ~we0;
            rv1_q <= gnt1 & ~we1;
        end
    end

    // Port 0 fields are presented whenever port 1 is not the winner.
    assign win_load = (gnt1 ? 1'(PORT_LOAD) : 1'(PORT_CORE)) == 1'(PORT_LOAD);
    assign mem_addr = win_load ? addr1  : addr0;
    assign mem_din  = win_load ? wdata1 : wdata0;
    assign mem_we   = (gnt0 & we0) | (gnt1 & we1);

    // A read in flight when reset arrives is never reported.
    assign rvalid0 = rv0_q & reset;
    assign rvalid1 = rv1_q & reset;
    assign rdata   = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a per-cycle reference model and memory macro.
module tb_mem_arbiter;

`ifdef MEM_ARB_AGE_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [15:0] rdata, mem_din;
    logic [7:0]  mem_addr;
    logic [15:0] mem_dout = '0;

    logic [15:0] macro_mem [256];
    logic [15:0] ref_mem   [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    // Memory macro: synchronous read returning the pre-write contents.
    always @(posedge clk) begin
        mem_dout <= macro_mem[mem_addr];
        if (mem_we) macro_mem[mem_addr] <= mem_din;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: abstract arbitration rules plus a scoreboard memory.
    bit          m_locked = 1'b0;
    int          m_denied = 0;
    bit          m_pend0 = 1'b0, m_pend1 = 1'b0;
    logic [15:0] m_pdata = '0;
    logic        e_g0, e_g1, e_we;
    logic [7:0]  e_addr;
    logic [15:0] e_din;

    always @(negedge clk) begin
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (reset) begin
            if (m_locked)                                         e_g1 = req1;
            else if (req1 && (!req0 || (AGE && m_denied >= MAXW))) e_g1 = 1'b1;
            else                                                  e_g0 = req0;
        end
        e_we   = (e_g0 && we0) || (e_g1 && we1);
        e_addr = e_g1 ? addr1 : addr0;
        e_din  = e_g1 ? wdata1 : wdata0;

        chk("gnt0", 32'(gnt0), 32'(e_g0));
        chk("gnt1", 32'(gnt1), 32'(e_g1));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) chk("mem_din", 32'(mem_din), 32'(e_din));
        chk("rvalid0", 32'(rvalid0), 32'(reset && m_pend0));
        chk("rvalid1", 32'(rvalid1), 32'(reset && m_pend1));
        if (reset && (m_pend0 || m_pend1)) chk("rdata", 32'(rdata), 32'(m_pdata));

        if (!reset) begin
            m_locked = 1'b0;
            m_denied = 0;
            m_pend0  = 1'b0;
            m_pend1  = 1'b0;
        end else begin
            m_pend0 = e_g0 && !we0;
            m_pend1 = e_g1 && !we1;
            if (e_g0 || e_g1) m_pdata = ref_mem[e_addr];
            if (e_we) ref_mem[e_addr] = e_din;
            if (m_locked && !lock1)            m_locked = 1'b0;
            else if (!m_locked && e_g1 && lock1) m_locked = 1'b1;
            if (e_g1 || !req1)        m_denied = 0;
            else if (m_denied < MAXW) m_denied = m_denied + 1;
        end
    end

    task automatic cyc(input logic rst,
                       input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1,
                       input logic l1);
        @(posedge clk);
        #1;
        reset = rst;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        lock1 = l1;
        #2;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            macro_mem[i] = {8'hC3, 8'(i)};
            ref_mem[i]   = {8'hC3, 8'(i)};
        end
        macro_mem[8'h10] = 16'h1234;
        ref_mem[8'h10]   = 16'h1234;
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1;

        // Reset with both ports requesting
        for (int c = 0; c < 2; c++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'h05, 16'hDEAD, 1'b1, 1'b1, 8'h06, 16'hBEEF, 1'b0);
            chk("rst_gnt0", 32'(gnt0), 32'd0);
            chk("rst_gnt1", 32'(gnt1), 32'd0);
            chk("rst_we", 32'(mem_we), 32'd0);
            chk("rst_rv", 32'({rvalid0, rvalid1}), 32'd0);
        end
        idle();

        // Port 0 read
        cyc(1'b1, 1'b1, 1'b0, 8'h10, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
        chk("p0rd_gnt0", 32'(gnt0), 32'd1);
        chk("p0rd_addr", 32'(mem_addr), 32'h10);
        idle();
        chk("p0rd_rv0", 32'(rvalid0), 32'd1);
        chk("p0rd_rdata", 32'(rdata), 32'h1234);
        chk("p0rd_rv1", 32'(rvalid1), 32'd0);

        // Contention: port 0 wins until it drops
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'h11, 16'h0, 1'b1, 1'b0, 8'h12, 16'h0, 1'b0);
            chk("cont_gnt0", 32'(gnt0), 32'd1);
            chk("cont_gnt1", 32'(gnt1), 32'd0);
        end
        cyc(1'b1, 1'b0, 1'b0, 8'h11, 16'h0, 1'b1, 1'b0, 8'h12, 16'h0, 1'b0);
        chk("cont_drop_gnt1", 32'(gnt1), 32'd1);
        idle();
        chk("cont_rv1", 32'(rvalid1), 32'd1);
        chk("cont_rdata", 32'(rdata), 32'hC312);

        // Aging under continuous contention
        for (int c = 0; c < 6; c++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'h13, 16'h0, 1'b1, 1'b0, 8'h14, 16'h0, 1'b0);
            chk("age_gnt1", 32'(gnt1), 32'(AGE && c == 4));
            chk("age_gnt0", 32'(gnt0), 32'(!(AGE && c == 4)));
        end
        idle();

        // Locked burst with port 0 requesting from the second beat
        cyc(1'b1, 1'b0, 1'b0, 8'h30, 16'h0, 1'b1, 1'b1, 8'h20, 16'hA0A0, 1'b1);
        chk("lock_b0", 32'({gnt0, gnt1}), 32'b01);
        cyc(1'b1, 1'b1, 1'b0, 8'h30, 16'h0, 1'b1, 1'b1, 8'h21, 16'hA0A1, 1'b1);
        chk("lock_b1", 32'({gnt0, gnt1}), 32'b01);
        cyc(1'b1, 1'b1, 1'b0, 8'h30, 16'h0, 1'b1, 1'b1, 8'h22, 16'hA0A2, 1'b0);
        chk("lock_b2", 32'({gnt0, gnt1}), 32'b01);
        cyc(1'b1, 1'b1, 1'b0, 8'h30, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
        chk("lock_after", 32'({gnt0, gnt1}), 32'b10);
        cyc(1'b1, 1'b1, 1'b0, 8'h20, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
        chk("lock_rd30", 32'(rdata), 32'hC330);
        cyc(1'b1, 1'b1, 1'b0, 8'h21, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
        chk("rb_20", 32'(rdata), 32'hA0A0);
        cyc(1'b1, 1'b1, 1'b0, 8'h22, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
        chk("rb_21", 32'(rdata), 32'hA0A1);
        idle();
        chk("rb_22", 32'(rdata), 32'hA0A2);

        // Read then write to the same address back-to-back
        cyc(1'b1, 1'b1, 1'b0, 8'h40, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'h40, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
        chk("rw_prewrite", 32'(rdata), 32'hC340);
        chk("rw_we", 32'(mem_we), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 8'h40, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
        chk("rw_wr_rv0", 32'(rvalid0), 32'd0);
        idle();
        chk("rw_postwrite", 32'(rdata), 32'hBEEF);

        // Reset arriving the cycle after a port 1 read grant
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h12, 16'h0, 1'b0);
        chk("rstrd_gnt1", 32'(gnt1), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
        chk("rstrd_rv1", 32'(rvalid1), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h10, 16'h0, 1'b0);
        chk("rstrd_rv1_rel", 32'(rvalid1), 32'd0);
        chk("rstrd_gnt1_rel", 32'(gnt1), 32'd1);
        idle();
        chk("rstrd_rv1_new", 32'(rvalid1), 32'd1);
        chk("rstrd_rdata", 32'(rdata), 32'h1234);

        // No requests: memory untouched
        repeat (3) begin
            idle();
            chk("idle_gnt", 32'({gnt0, gnt1, mem_we}), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port synchronous program/data memory between two requesters: the core controller (port 0) and the program loader / debug DMA (port 1). It grants at most one memory access per cycle and returns read data one cycle after the grant. It sits between the requesters and the memory macro. It replaces the direct core-to-memory connection (`s_addr`/`we_mem` path) so that programs can be loaded or inspected while the core is held or running.

## Interface
- `ADDR_W`, 8, memory address width
- `DATA_W`, 16, memory data width
- `MAX_WAIT`, 4, denied cycles before port 1 gains priority (aging; range 1..15)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets the block
- `req0`, `req1` in 1: access request; held with command stable until granted
- `we0`, `we1` in 1: 1 = write, 0 = read
- `addr0`, `addr1` in ADDR_W: access address
- `wdata0`, `wdata1` in DATA_W: write data
- `lock1` in 1: port 1 burst lock
- `gnt0`, `gnt1` out 1: combinational grant; access issued this cycle
- `rvalid0`, `rvalid1` out 1: registered; read data valid
- `rdata` out DATA_W: equals `mem_dout`; qualify it with `rvalid*`
- `mem_addr` out ADDR_W, `mem_din` out DATA_W, `mem_we` out 1: memory command
- `mem_dout` in DATA_W: memory read data, 1-cycle synchronous read

## Operation
- FSM states: ARB and LOCKED. Reset state is ARB.
- ARB: winner is chosen from the requesting ports.
  - Default priority: port 0 over port 1.
  - Port 1 wins when `wait_cnt == MAX_WAIT`.
  - If port 1 wins with `lock1==1`, the next state is LOCKED.
- LOCKED: only port 1 can be granted; `gnt0` is held at 0.
  - Return to ARB at the first cycle where `lock1==0`. That cycle still arbitrates as LOCKED.
  - Port 0 is first eligible the following cycle.
- Memory command:
  - `mem_addr`/`mem_din` come from the winner. With no grant, port 0 fields are driven.
  - `mem_we = gnt & we` of the winner.
- Read return: `rvalidN` is registered as `gntN & !weN` and pulses for one cycle.
- `wait_cnt` (4 bits):
  - Increments when `req1 & !gnt1`, saturating at `MAX_WAIT`.
  - Clears on `gnt1` or `!req1`.
- Back-to-back grants are allowed every cycle, including read→write to the same address. A read issued at cycle N returns the pre-write data.
- Reset values: state ARB, `wait_cnt` 0, `rvalid0`/`rvalid1` 0.
- Reset asserted the cycle after a read grant: `rvalid` stays 0; the pending read is dropped.
- While `reset==0`, `gnt0`, `gnt1` and `mem_we` are forced to 0.
- With no requests, all grants are 0 and memory contents are unchanged.

## Timing
- Grant latency is 0 cycles: `gnt` rises in the same cycle as `req` when the port wins.
- Write completes at the grant edge.
- Read: `rvalid` and `rdata` are valid at cycle N+1 for a grant at cycle N.
- The requester drops `req`, or presents a new command, in the cycle after `gnt`.
- Worst-case port 1 wait in ARB with aging is `MAX_WAIT` cycles.
- Port 0 wait is unbounded while `lock1` is held; this is by design, and the loader bounds its bursts.

## Configuration
- `MEM_ARB_AGE_EN` defined: aging counter is present; port 1 is guaranteed a grant within `MAX_WAIT` denied cycles.
- `MEM_ARB_AGE_EN` undefined:
  - No counter; strict port 0 priority in ARB, and `MAX_WAIT` is ignored.
  - Port 1 is granted only when `req0==0`, or via LOCKED.

## Structure
- Package `mem_arb_pkg`:
  - FSM state encoding (ARB=0, LOCKED=1)
  - port index constants (`PORT_CORE=0`, `PORT_LOAD=1`)
  - counter width constant (4)
- Sub-module `mem_arb_age_ctr`: saturating wait counter with `inc`, `clr` and `at_max` outputs. It is instantiated only under `MEM_ARB_AGE_EN`.
- Top level holds the FSM, winner mux and `rvalid` registers.

## Test plan
- **Reset:** hold `reset=0` 2 cycles with both ports requesting → all `gnt`, `rvalid` and `mem_we` are 0; state is ARB after release.
- **Port 0 read:** mem[0x10]=0x1234; `req0`, `we0=0`, `addr0=0x10` → `gnt0` same cycle; `rvalid0=1`, `rdata=0x1234` next cycle; `rvalid1` stays 0.
- **Contention without aging:** both ports request continuously for 3 cycles → `gnt0` each cycle. Drop `req0` → `gnt1` that cycle.
- **Aging (macro on, MAX_WAIT=4):** both ports request continuously →
  - `gnt0` on cycles 0–3; `gnt1` on cycle 4; `gnt0` again on cycle 5.
  - With the macro off, `gnt1` is never asserted.
- **Locked burst:** port 1 writes 0xA0A0, 0xA0A1, 0xA0A2 to 0x20–0x22 with `lock1=1` on the first two and `0` on the third, while `req0` is held → `gnt1` on 3 consecutive cycles, then `gnt0`; memory reads back the three values.
- **Reset mid-read:** grant a port 1 read, then `reset=0` the next cycle → `rvalid1` stays 0, and the first grant after release behaves normally.
